// File: rtl/rt_multi_sphere_core.sv
// Per-pixel ray caster over a small run-time loadable sphere table.
// One pixel in flight at a time: SETUP, then OC/PROD/TEST for every table
// entry (disabled ones included, so latency is fixed), then DONE holds the
// nearest-hit result until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a pixel; table writes allowed
// SETUP | ray direction d and |d|^2 from the latched pixel
// OC    | camera-to-centre vector for entry cur
// PROD  | oc x d and oc . d for entry cur
// TEST  | hit test for entry cur, update nearest
// DONE  | result presented, waiting for OUT_READY
module rt_multi_sphere_core #(
  parameter int COORD_W     = 16,
  parameter int NUM_SPHERES = 4,
  parameter int COLOR_W     = 4,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int FOCAL       = 1000,
  parameter int CAM_X       = 320,
  parameter int CAM_Y       = 240,
  parameter int BG_COLOR    = 0,
  parameter int IDX_W       = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [X_W-1:0]            X_IN,
  input  logic [Y_W-1:0]            Y_IN,
  input  logic                      SPH_WE,
  input  logic [IDX_W-1:0]          SPH_IDX,
  input  logic                      SPH_EN,
  input  logic signed [COORD_W-1:0] SPH_CX,
  input  logic signed [COORD_W-1:0] SPH_CY,
  input  logic signed [COORD_W-1:0] SPH_CZ,
  input  logic [COORD_W-1:0]        SPH_R,
  input  logic [COLOR_W-1:0]        SPH_COLOR,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [COLOR_W-1:0]        OUT_PIXEL,
  output logic                      OUT_HIT,
  output logic [IDX_W-1:0]          OUT_IDX
);

  // oc needs one extra bit over the centre, d two extra bits so that the
  // screen offsets and FOCAL fit; every later width follows from those.
  localparam int OC_W = COORD_W + 1;
  localparam int D_W  = COORD_W + 2;
  localparam int P_W  = 2 * (COORD_W + 2);
  localparam int OD_W = P_W + 2;
  localparam int S_W  = 4 * (COORD_W + 2) + 2;

  localparam logic signed [OC_W-1:0] CAM_X_OC = OC_W'(CAM_X);
  localparam logic signed [OC_W-1:0] CAM_Y_OC = OC_W'(CAM_Y);
  localparam logic signed [D_W-1:0]  CAM_X_D  = D_W'(CAM_X);
  localparam logic signed [D_W-1:0]  CAM_Y_D  = D_W'(CAM_Y);
  localparam logic signed [D_W-1:0]  FOCAL_D  = D_W'(FOCAL);
  localparam logic signed [OD_W-1:0] OD_ZERO  = '0;
  localparam logic [COLOR_W-1:0]     BG       = COLOR_W'(BG_COLOR);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_SPHERES - 1);
  localparam logic [IDX_W:0]         NUM_CNT  = (IDX_W + 1)'(NUM_SPHERES);

  typedef enum logic [2:0] {IDLE, SETUP, OC, PROD, TEST, DONE} state_t;

  state_t state_q, state_d;

  logic                      tbl_en    [NUM_SPHERES];
  logic signed [COORD_W-1:0] tbl_cx    [NUM_SPHERES];
  logic signed [COORD_W-1:0] tbl_cy    [NUM_SPHERES];
  logic signed [COORD_W-1:0] tbl_cz    [NUM_SPHERES];
  logic [COORD_W-1:0]        tbl_r     [NUM_SPHERES];
  logic [COLOR_W-1:0]        tbl_color [NUM_SPHERES];

  logic [X_W-1:0]         x_lat;
  logic [Y_W-1:0]         y_lat;
  logic signed [D_W-1:0]  dx, dy, dz;
  logic signed [OD_W-1:0] dd;
  logic signed [OC_W-1:0] ocx, ocy, ocz;
  logic signed [P_W-1:0]  cr_x, cr_y, cr_z;
  logic signed [OD_W-1:0] od;
  logic [IDX_W-1:0]       cur;
  logic                   best_valid;
  logic signed [OD_W-1:0] best_od;
  logic [IDX_W-1:0]       best_idx;
  logic [COLOR_W-1:0]     best_color;

  logic signed [D_W-1:0]  dx_c, dy_c;
  logic signed [S_W-1:0]  cr2, r2dd, r_e, dd_e;
  logic                   hit, upd, last, wr_ok;

  function automatic logic signed [P_W-1:0] mul_p(input logic signed [OC_W-1:0] a,
                                                  input logic signed [D_W-1:0] b);
    logic signed [P_W-1:0] ae, be;
    ae = P_W'(a);
    be = P_W'(b);
    return ae * be;
  endfunction

  function automatic logic signed [OD_W-1:0] sq_d(input logic signed [D_W-1:0] a);
    logic signed [OD_W-1:0] ae;
    ae = OD_W'(a);
    return ae * ae;
  endfunction

  function automatic logic signed [S_W-1:0] sq_s(input logic signed [P_W-1:0] a);
    logic signed [S_W-1:0] ae;
    ae = S_W'(a);
    return ae * ae;
  endfunction

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_d = SETUP;
      end
      SETUP: state_d = OC;
      OC:    state_d = PROD;
      PROD:  state_d = TEST;
      TEST:  state_d = last ? DONE : OC;
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ray direction for the latched pixel and the hit test for the current entry.
  // The tangent case lands on equality and counts as a hit.
  always_comb begin
    dx_c  = $signed(D_W'(x_lat)) - CAM_X_D;
    dy_c  = $signed(D_W'(y_lat)) - CAM_Y_D;
    cr2   = sq_s(cr_x) + sq_s(cr_y) + sq_s(cr_z);
    r_e   = S_W'(tbl_r[cur]);
    dd_e  = S_W'(dd);
    r2dd  = r_e * r_e * dd_e;
    hit   = tbl_en[cur] && (od > OD_ZERO) && (cr2 <= r2dd);
    upd   = hit && (!best_valid || (od < best_od));
    last  = (cur == LAST_IDX);
    wr_ok = SPH_WE && IN_READY && ({1'b0, SPH_IDX} < NUM_CNT);
  end

  // Sphere table: writable only while idle, enables cleared by reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NUM_SPHERES; k++) begin
        tbl_en[k]    <= 1'b0;
        tbl_cx[k]    <= '0;
        tbl_cy[k]    <= '0;
        tbl_cz[k]    <= '0;
        tbl_r[k]     <= '0;
        tbl_color[k] <= '0;
      end
    end else if (wr_ok) begin
      tbl_en[SPH_IDX]    <= SPH_EN;
      tbl_cx[SPH_IDX]    <= SPH_CX;
      tbl_cy[SPH_IDX]    <= SPH_CY;
      tbl_cz[SPH_IDX]    <= SPH_CZ;
      tbl_r[SPH_IDX]     <= SPH_R;
      tbl_color[SPH_IDX] <= SPH_COLOR;
    end
  end

  // Per-state datapath: latch, setup, oc, products, nearest tracking, result.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_lat      <= '0;
      y_lat      <= '0;
      dx         <= '0;
      dy         <= '0;
      dz         <= '0;
      dd         <= '0;
      ocx        <= '0;
      ocy        <= '0;
      ocz        <= '0;
      cr_x       <= '0;
      cr_y       <= '0;
      cr_z       <= '0;
      od         <= '0;
      cur        <= '0;
      best_valid <= 1'b0;
      best_od    <= '0;
      best_idx   <= '0;
      best_color <= BG;
      OUT_PIXEL  <= BG;
      OUT_HIT    <= 1'b0;
      OUT_IDX    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            x_lat <= X_IN;
            y_lat <= Y_IN;
          end
        end
        SETUP: begin
          dx         <= dx_c;
          dy         <= dy_c;
          dz         <= FOCAL_D;
          dd         <= sq_d(dx_c) + sq_d(dy_c) + sq_d(FOCAL_D);
          best_valid <= 1'b0;
          cur        <= '0;
        end
        OC: begin
          ocx <= OC_W'(tbl_cx[cur]) - CAM_X_OC;
          ocy <= OC_W'(tbl_cy[cur]) - CAM_Y_OC;
          ocz <= OC_W'(tbl_cz[cur]);
        end
        PROD: begin
          cr_x <= mul_p(ocy, dz) - mul_p(ocz, dy);
          cr_y <= mul_p(ocz, dx) - mul_p(ocx, dz);
          cr_z <= mul_p(ocx, dy) - mul_p(ocy, dx);
          od   <= OD_W'(mul_p(ocx, dx)) + OD_W'(mul_p(ocy, dy)) + OD_W'(mul_p(ocz, dz));
        end
        TEST: begin
          // Strict less-than keeps the lower index on equal distance.
          if (upd) begin
            best_valid <= 1'b1;
            best_od    <= od;
            best_idx   <= cur;
            best_color <= tbl_color[cur];
          end
          if (last) begin
            if (upd) begin
              OUT_PIXEL <= tbl_color[cur];
              OUT_HIT   <= 1'b1;
              OUT_IDX   <= cur;
            end else if (best_valid) begin
              OUT_PIXEL <= best_color;
              OUT_HIT   <= 1'b1;
              OUT_IDX   <= best_idx;
            end else begin
              OUT_PIXEL <= BG;
              OUT_HIT   <= 1'b0;
              OUT_IDX   <= '0;
            end
          end else begin
            cur <= cur + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rt_multi_sphere_core.sv
// Bench for rt_multi_sphere_core: directed scenes with hand-derived results,
// then random scenes checked against a ray/sphere discriminant model.
module tb_rt_multi_sphere_core;

  localparam int NS  = 4;
  localparam int LAT = 2 + 3 * NS;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              IN_VALID = 1'b0;
  logic              IN_READY;
  logic [9:0]        X_IN = '0;
  logic [8:0]        Y_IN = '0;
  logic              SPH_WE = 1'b0;
  logic [1:0]        SPH_IDX = '0;
  logic              SPH_EN = 1'b0;
  logic signed [15:0] SPH_CX = '0, SPH_CY = '0, SPH_CZ = '0;
  logic [15:0]       SPH_R = '0;
  logic [3:0]        SPH_COLOR = '0;
  logic              OUT_VALID;
  logic              OUT_READY = 1'b1;
  logic [3:0]        OUT_PIXEL;
  logic              OUT_HIT;
  logic [1:0]        OUT_IDX;

  rt_multi_sphere_core dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .X_IN(X_IN), .Y_IN(Y_IN), .SPH_WE(SPH_WE), .SPH_IDX(SPH_IDX), .SPH_EN(SPH_EN),
    .SPH_CX(SPH_CX), .SPH_CY(SPH_CY), .SPH_CZ(SPH_CZ), .SPH_R(SPH_R),
    .SPH_COLOR(SPH_COLOR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_PIXEL(OUT_PIXEL), .OUT_HIT(OUT_HIT), .OUT_IDX(OUT_IDX)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] p;
    logic       h;
    logic [1:0] i;
  } res_t;

  res_t exp_q[$];
  int   acc_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  int   n_acc   = 0;
  bit   prev_ov = 1'b0;

  bit m_en  [NS];
  int m_cx  [NS];
  int m_cy  [NS];
  int m_cz  [NS];
  int m_r   [NS];
  int m_col [NS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // A sphere is hit when the ray line meets it: (oc.d)^2 - |d|^2(|oc|^2 - r^2) >= 0,
  // and it lies in front (oc.d > 0). Nearest = smallest oc.d, first index on ties.
  function automatic res_t model(input int x, input int y);
    longint dx, dy, dz, dd, ox, oy, oz, od, oo, rr, disc, best;
    int     bi;
    res_t   r;
    dx = x - 320;
    dy = y - 240;
    dz = 1000;
    dd = dx * dx + dy * dy + dz * dz;
    bi = -1;
    best = 0;
    for (int k = 0; k < NS; k++) begin
      if (m_en[k]) begin
        ox = m_cx[k] - 320;
        oy = m_cy[k] - 240;
        oz = m_cz[k];
        od = ox * dx + oy * dy + oz * dz;
        oo = ox * ox + oy * oy + oz * oz;
        rr = longint'(m_r[k]) * m_r[k];
        disc = od * od - dd * (oo - rr);
        if (od > 0 && disc >= 0 && (bi < 0 || od < best)) begin
          bi = k;
          best = od;
        end
      end
    end
    if (bi < 0) begin
      r.p = 4'd0;
      r.h = 1'b0;
      r.i = 2'd0;
    end else begin
      r.p = 4'(m_col[bi]);
      r.h = 1'b1;
      r.i = 2'(bi);
    end
    return r;
  endfunction

  // Monitor: records accepts, checks latency on each new result and compares
  // every consumed result with the head of the expected queue.
  initial begin
    int   t;
    res_t e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        acc_q.delete();
        prev_ov = 1'b0;
      end else begin
        if (IN_VALID && IN_READY) begin
          acc_q.push_back(cyc);
          n_acc++;
        end
        if (OUT_VALID && !prev_ov) begin
          if (acc_q.size() == 0) fail_now("unexpected_out_valid");
          else begin
            t = acc_q.pop_front();
            chk("latency", 64'(cyc - t), 64'(LAT));
          end
        end
        if (OUT_VALID && OUT_READY) begin
          n_out++;
          if (exp_q.size() == 0) fail_now("unexpected_result");
          else begin
            e = exp_q.pop_front();
            chk("out_pixel", 64'(OUT_PIXEL), 64'(e.p));
            chk("out_hit", 64'(OUT_HIT), 64'(e.h));
            chk("out_idx", 64'(OUT_IDX), 64'(e.i));
          end
        end
        prev_ov = OUT_VALID;
      end
    end
  end

  task automatic write_sph(input int idx, input bit en, input int cx, input int cy,
                           input int cz, input int r, input int col, input bit upd_model);
    @(posedge CLK); #1;
    SPH_WE    = 1'b1;
    SPH_IDX   = idx[1:0];
    SPH_EN    = en;
    SPH_CX    = cx[15:0];
    SPH_CY    = cy[15:0];
    SPH_CZ    = cz[15:0];
    SPH_R     = r[15:0];
    SPH_COLOR = col[3:0];
    @(posedge CLK); #1;
    SPH_WE = 1'b0;
    if (upd_model) begin
      m_en[idx] = en;  m_cx[idx] = cx;  m_cy[idx] = cy;
      m_cz[idx] = cz;  m_r[idx]  = r;   m_col[idx] = col;
    end
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge CLK);
      if (IN_READY) ok = 1'b1;
    end
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      fail_now("result_timeout");
      exp_q.delete();
    end
  endtask

  task automatic issue_exp(input int x, input int y, input int p, input int h, input int i);
    res_t e;
    @(posedge CLK); #1;
    IN_VALID = 1'b1;
    X_IN = x[9:0];
    Y_IN = y[8:0];
    wait_accept();
    e.p = p[3:0];
    e.h = h[0];
    e.i = i[1:0];
    exp_q.push_back(e);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    drain();
  endtask

  task automatic issue_model(input int x, input int y);
    @(posedge CLK); #1;
    IN_VALID = 1'b1;
    X_IN = x[9:0];
    Y_IN = y[8:0];
    wait_accept();
    exp_q.push_back(model(x, y));
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   snap, x, y, j, idx, cx, cy, cz, r, nw;
    bit   ok;
    res_t e;
    for (int k = 0; k < NS; k++) begin
      m_en[k] = 0; m_cx[k] = 0; m_cy[k] = 0; m_cz[k] = 0; m_r[k] = 0; m_col[k] = 0;
    end

    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", 64'(IN_READY), 64'd1);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_out_pixel", 64'(OUT_PIXEL), 64'd0);
    chk("rst_out_hit", 64'(OUT_HIT), 64'd0);
    chk("rst_out_idx", 64'(OUT_IDX), 64'd0);

    issue_exp(320, 240, 0, 0, 0);

    write_sph(0, 1, 320, 240, 1100, 100, 15, 1);
    issue_exp(320, 240, 15, 1, 0);
    issue_exp(0, 0, 0, 0, 0);

    write_sph(0, 1, 320, 240, 2000, 100, 5, 1);
    write_sph(1, 1, 320, 240, 1100, 100, 3, 1);
    issue_exp(320, 240, 3, 1, 1);

    write_sph(0, 1, 320, 240, 1100, 100, 3, 1);
    write_sph(1, 1, 320, 240, 2000, 100, 5, 1);
    issue_exp(320, 240, 3, 1, 0);

    write_sph(0, 1, 320, 240, 1500, 100, 5, 1);
    write_sph(1, 1, 320, 240, 1500, 100, 9, 1);
    issue_exp(320, 240, 5, 1, 0);

    write_sph(0, 0, 0, 0, 0, 0, 0, 1);
    write_sph(1, 0, 0, 0, 0, 0, 0, 1);
    write_sph(3, 1, 320, 240, 1100, 100, 6, 1);
    issue_exp(320, 240, 6, 1, 3);
    write_sph(3, 0, 0, 0, 0, 0, 0, 1);

    write_sph(0, 1, 320, 240, 1000, 100, 10, 1);
    issue_exp(420, 240, 10, 1, 0);
    issue_exp(440, 240, 0, 0, 0);

    write_sph(0, 1, 320, 240, -1100, 100, 10, 1);
    issue_exp(320, 240, 0, 0, 0);
    write_sph(0, 0, 320, 240, 1100, 100, 10, 1);
    issue_exp(320, 240, 0, 0, 0);

    // Backpressure with a second request pending and table writes while busy.
    write_sph(0, 1, 320, 240, 1100, 100, 15, 1);
    OUT_READY = 1'b0;
    @(posedge CLK); #1;
    IN_VALID = 1'b1;
    X_IN = 10'd320;
    Y_IN = 9'd240;
    wait_accept();
    e.p = 4'hF; e.h = 1'b1; e.i = 2'd0;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    SPH_WE = 1'b1; SPH_IDX = 2'd0; SPH_EN = 1'b0; SPH_COLOR = 4'd7; SPH_CZ = -16'sd1100;
    repeat (3) @(posedge CLK);
    #1 SPH_WE = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge CLK);
      if (OUT_VALID) ok = 1'b1;
    end
    if (!ok) fail_now("hold_out_valid_timeout");
    snap = n_acc;
    repeat (5) begin
      @(negedge CLK);
      chk("hold_out_valid", 64'(OUT_VALID), 64'd1);
      chk("hold_in_ready", 64'(IN_READY), 64'd0);
      chk("hold_out_pixel", 64'(OUT_PIXEL), 64'd15);
      chk("hold_out_hit", 64'(OUT_HIT), 64'd1);
      chk("hold_out_idx", 64'(OUT_IDX), 64'd0);
    end
    chk("hold_no_second_accept", 64'(n_acc), 64'(snap));
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    wait_accept();
    exp_q.push_back(e);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    drain();

    // Reset in cycle 6 of a pixel: nothing emitted, table enables cleared.
    @(posedge CLK); #1;
    IN_VALID = 1'b1;
    wait_accept();
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    snap = n_out;
    for (int k = 0; k < NS; k++) m_en[k] = 0;
    @(negedge CLK);
    chk("mid_rst_in_ready", 64'(IN_READY), 64'd1);
    chk("mid_rst_out_valid", 64'(OUT_VALID), 64'd0);
    repeat (25) @(negedge CLK);
    chk("mid_rst_no_result", 64'(n_out), 64'(snap));
    issue_exp(320, 240, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      nw = int'($urandom_range(1, 2));
      for (int w = 0; w < nw; w++) begin
        idx = int'($urandom_range(0, NS - 1));
        if ($urandom_range(0, 4) == 0) begin
          j  = int'($urandom_range(0, NS - 1));
          cx = m_cx[j]; cy = m_cy[j]; cz = m_cz[j];
        end else begin
          cx = 320 + int'($urandom_range(0, 1200)) - 600;
          cy = 240 + int'($urandom_range(0, 1200)) - 600;
          cz = int'($urandom_range(0, 3500)) - 500;
        end
        r = int'($urandom_range(0, 600));
        write_sph(idx, $urandom_range(0, 4) != 0, cx, cy, cz, r, int'($urandom_range(0, 15)), 1);
      end
      j = int'($urandom_range(0, NS - 1));
      if ($urandom_range(0, 1) == 1 && m_cz[j] > 100) begin
        x = 320 + (m_cx[j] - 320) * 1000 / m_cz[j] + int'($urandom_range(0, 60)) - 30;
        y = 240 + (m_cy[j] - 240) * 1000 / m_cz[j] + int'($urandom_range(0, 60)) - 30;
      end else begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 511));
      end
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 511) y = 511;
      issue_model(x, y);
    end

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
